// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the RV32IM instruction fetch stage.
//   fetch_entry_t  : one buffered fetch result {pc, instr}
//   fetch_state_t  : control FSM states {BOOT, RUN}
//   DEF_RESET_PC   : default first fetch address
//   PC_INC         : sequential PC step (one 32-bit instruction)
//   word_align()   : forces an address onto a word boundary
package ifetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: bundles the instruction-memory port, the execute redirect and
// the decode handshake of the fetch stage.
//   iaddr_o/ird_o/irdata_i            : synchronous instruction memory port
//   branch_taken_i/jump_addr_i        : redirect request from execute
//   stall_i                           : downstream cannot accept this cycle
//   if_valid_o/if_instr_o/if_pc_o     : presented instruction towards decode
// Modports: master = fetch stage, slave = memory/pipeline environment.
interface ifetch_if;

  logic [31:0] iaddr_o;
  logic        ird_o;
  logic [31:0] irdata_i;
  logic        branch_taken_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  modport master (
    output iaddr_o, ird_o, if_valid_o, if_instr_o, if_pc_o,
    input  irdata_i, branch_taken_i, jump_addr_i, stall_i
  );

  modport slave (
    input  iaddr_o, ird_o, if_valid_o, if_instr_o, if_pc_o,
    output irdata_i, branch_taken_i, jump_addr_i, stall_i
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small circular skid buffer of fetch_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry at the tail
//   pop        : drop the head entry
//   flush      : discard all entries (wins over push/pop)
//   count      : number of stored entries, 0..DEPTH
//   head       : entry at the head (meaningful only when count != 0)
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // The fetch issue rule reserves a slot for every in-flight request.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: RV32IM instruction fetch stage.
// Drives the synchronous instruction memory, buffers returned words in a
// skid FIFO and presents {pc, instr} to decode with a valid/stall handshake.
// Taken branches/jumps from execute redirect the PC and flush buffered work.
//   clk_i, reset_i : clock, asynchronous active-low reset
//   bus            : ifetch_if.master (memory port, redirect, decode handshake)
//   fetch_cnt_o    : accepted-instruction counter   (IFETCH_PERF_CNT_EN only)
//   flush_cnt_o    : discarded-entry counter        (IFETCH_PERF_CNT_EN only)
// Parameters: RESET_PC (word-aligned first fetch address), DEPTH (>= 2).
// Optional feature macro: IFETCH_PERF_CNT_EN.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_t    state_q;
  logic [31:0]     pc_q;
  logic            pend_q;
  logic [31:0]     pend_pc_q;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    arrive_entry;
  fetch_entry_t    present_entry;
  logic [CW:0]     occupancy;
  logic            fifo_empty;
  logic            redirect;
  logic            issue;
  logic            present_valid;
  logic            accept;
  logic            push;
  logic            pop;

  assign redirect     = bus.branch_taken_i;
  assign fifo_empty   = (fifo_count == '0);
  assign arrive_entry = '{pc: pend_pc_q, instr: bus.irdata_i};

  // Buffered entries plus the in-flight request must leave room for one more
  // response, so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pend_q};
  assign issue     = (state_q == RUN) && !redirect && (occupancy < DEPTH_V);

  // The FIFO head has priority; an arriving word is bypassed only when the
  // FIFO is empty so program order is preserved.
  always_comb begin
    present_entry = '0;
    if (!fifo_empty) begin
      present_entry = fifo_head;
    end else if (pend_q) begin
      present_entry = arrive_entry;
    end
  end

  assign present_valid = !redirect && (!fifo_empty || pend_q);
  assign accept        = present_valid && !bus.stall_i;
  assign pop           = accept && !fifo_empty;
  assign push          = pend_q && !redirect && !(accept && fifo_empty);

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_i),
    .push  (push),
    .wdata (arrive_entry),
    .pop   (pop),
    .flush (redirect),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign bus.iaddr_o    = pc_q;
  assign bus.ird_o      = issue;
  assign bus.if_valid_o = present_valid;
  assign bus.if_instr_o = present_entry.instr;
  assign bus.if_pc_o    = present_entry.pc;

  // Control FSM and PC/request tracking. A redirect loads the target even
  // during BOOT; the response to a request issued before a redirect is never
  // outstanding because no request is issued in the redirect cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= BOOT;
      endcase

      if (redirect) begin
        pc_q <= word_align(bus.jump_addr_i);
      end else if (issue) begin
        pc_q <= pc_q + PC_INC;
      end

      pend_q <= issue;
      if (issue) begin
        pend_pc_q <= pc_q;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // A redirect discards every buffered entry plus the word arriving now.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (accept) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (redirect) begin
        flush_cnt_o <= flush_cnt_o + 32'(fifo_count) + 32'(pend_q);
      end
    end
  end
`endif

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage of the RV32IM pipeline. Drives the synchronous instruction memory and buffers returned words in a small skid FIFO. Presents `{pc, instr}` to decode with a valid/stall handshake. Redirects on taken branches and jumps from execute. Sits directly upstream of decode, where `id_pc_r`/`id_next_pc_r` are registered.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address; bits [1:0] must be 0.
- `DEPTH`, default 2: skid FIFO entries; minimum 2.

- `clk_i` in 1: clock, all flops rising edge.
- `reset_i` in 1: reset, asynchronous, active-low.
- `iaddr_o` out 32: instruction memory address, always word-aligned.
- `ird_o` out 1: instruction read request.
- `irdata_i` in 32: read data, valid the cycle after `ird_o`; memory always ready.
- `branch_taken_i` in 1: redirect request from execute.
- `jump_addr_i` in 32: redirect target; bits [1:0] ignored.
- `stall_i` in 1: decode/execute cannot accept this cycle (e.g. divider busy).
- `if_valid_o` out 1: `if_instr_o`/`if_pc_o` hold a valid instruction.
- `if_instr_o` out 32: instruction word.
- `if_pc_o` out 32: its address.

## Operation
- Registered state:
  - `pc_q`, which drives `iaddr_o`.
  - `pend_q`, set when a request is in flight.
  - `pend_pc_q`, the PC of that request.
  - FIFO of `{pc, instr}` entries with `count_q` in 0..DEPTH.
- Control FSM:
  - BOOT: first cycle after reset release; `ird_o`=0.
  - RUN: normal operation.
- Issue: `ird_o = RUN && !branch_taken_i && (count_q + pend_q < DEPTH)`.
  - On issue: `pc_q += 4` (32-bit wrap; `0xFFFF_FFFC` → `0`), `pend_q`=1, `pend_pc_q`=`pc_q`.
  - No issue and no branch: `pc_q` holds.
- Response: when `pend_q`=1, `irdata_i` and `pend_pc_q` form the arriving entry.
- Output source:
  - FIFO empty: arriving entry is presented combinationally (bypass).
  - FIFO non-empty: FIFO head is presented.
  - `if_valid_o`=0 when neither exists.
- Accept: `if_valid_o && !stall_i && !branch_taken_i` pops the presented entry (head or bypass).
- An arriving entry that is not consumed by bypass is written to the FIFO tail.
- The issue rule guarantees a free slot, so overflow is impossible. Overflow is an assertion target, not handled.
- Redirect in cycle N (priority over stall and pop):
  - FIFO cleared and the arriving entry discarded in N.
  - `ird_o`=0 and `if_valid_o`=0 in N.
  - `pc_q <= {jump_addr_i[31:2],2'b00}`.
  - N+1: `iaddr_o`=target, `ird_o`=1.
  - N+2: target instruction valid.
- `branch_taken_i` in BOOT: target loaded; BOOT→RUN as normal.
- Reset asserted mid-operation: all state cleared immediately; any in-flight response is ignored.

## Timing
- Reset values:
  - `iaddr_o`=`RESET_PC`, `ird_o`=0, `if_valid_o`=0.
  - `if_instr_o`=0, `if_pc_o`=0, `count_q`=0, `pend_q`=0, FSM=BOOT.
- Fetch latency: issue at N → `if_valid_o` at N+1 via bypass.
- Steady state: one instruction per cycle.
- `stall_i` held:
  - After at most 2 further issues, `ird_o` drops and `iaddr_o` holds.
  - `if_*` outputs stay constant.
  - `irdata_i` stable per the memory contract.
- On `stall_i` release: first pop is the same cycle; issue resumes when `count_q + pend_q < DEPTH`.
- Redirect penalty: 2 cycles from `branch_taken_i` to target valid.

## Configuration
- `IFETCH_PERF_CNT_EN` defined: adds outputs `fetch_cnt_o` [31:0] and `flush_cnt_o` [31:0].
  - `fetch_cnt_o` increments per accepted instruction.
  - `flush_cnt_o` increments by the number of entries discarded per redirect (FIFO count + arriving entry).
  - Both counters reset to 0 and wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- `ifetch_pkg`:
  - `fetch_entry_t` (`pc`, `instr`).
  - FSM enum `{BOOT, RUN}`.
  - `DEF_RESET_PC`.
  - `PC_INC`=4.
- Sub-module `ifetch_fifo`: parameterised DEPTH, push/pop/flush, `count` output, head read. The same-cycle push+pop case keeps `count`.

## Test plan
- Reset release with RESET_PC=`0x100` → `ird_o`=1 at cycle 1 with `iaddr_o`=`0x100`; `if_valid_o`=1 at cycle 2 with `if_pc_o`=`0x100`; `0x104`,`0x108` follow on consecutive cycles.
- `stall_i` high for 5 cycles in steady state → at most 2 further issues; `count_q` reaches 2; `if_pc_o` constant; on release, PCs continue in order with no gap or duplicate.
- `branch_taken_i` with `jump_addr_i`=`0x2003` while FIFO holds 2 entries → both flushed; next `iaddr_o`=`0x2000`; `if_pc_o`=`0x2000` two cycles later.
- Simultaneous `branch_taken_i` and `stall_i` → redirect taken, no pop, FIFO empty next cycle.
- `pc_q`=`0xFFFF_FFFC` with no branch → next `iaddr_o`=`0x0000_0000`.
- With `IFETCH_PERF_CNT_EN`: 10 accepted instructions then a redirect with 2 buffered and 1 arriving → `fetch_cnt_o`=10, `flush_cnt_o`=3.
